reorder_buffer: RTL and testbench



---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_ring_ptr.sv | 55 +++++
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry kinds and the per-entry record.
// Pure declarations, no logic.
package rob_pkg;

    localparam int ROB_TAG_W = 4;

    typedef enum logic [1:0] {
        ROB_ALU    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2
    } rob_kind_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        rob_kind_t   kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred;
        logic        taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_ring_ptr.sv
// Head/tail/count bookkeeping for a power-of-two ring; pointers wrap naturally.
// Updates only when en_i is high; clr_i zeroes everything and wins over push/pop.
module rob_ring_ptr #(
    parameter int PW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [PW-1:0] head_o,
    output logic [PW-1:0] tail_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
            else if (!push_i && pop_i) count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    // count never exceeds 2^PW, so its MSB alone marks full
    assign full_o  = count_q[PW];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB completion, in-order commit with registered pulses (1 cycle after head done).
// rdy_in low freezes all state and masks pulses; define ROB_CDB_BYPASS_EN for same-cycle CDB forwarding on query ports.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [1:0]           issue_kind,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    output logic [DEPTH_LOG-1:0] issue_tag,
    output logic                 full,
    input  logic                 cdb_valid,
    input  logic [DEPTH_LOG-1:0] cdb_tag,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_taken,
    input  logic [DEPTH_LOG-1:0] query_tag_1,
    input  logic [DEPTH_LOG-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [31:0]          query_val_1,
    output logic [31:0]          query_val_2,
    output logic [4:0]           commit_reg,
    output logic [31:0]          commit_val,
    output logic [4:0]           commit_q_reg,
    output logic [31:0]          commit_q_tag,
    output logic                 store_commit,
    output logic                 rob_clear,
    output logic [31:0]          clear_pc
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    rob_entry_t ent_q [DEPTH];
    rob_entry_t ent_d [DEPTH];

    logic [DEPTH_LOG-1:0] head, tail;
    logic                 empty;
    logic                 commit_fire, issue_ok, cdb_ok;
    rob_entry_t           head_ent;

    logic [4:0]           creg_q, creg_d;
    logic [31:0]          cval_q, cval_d, cpc_q, cpc_d;
    logic [DEPTH_LOG-1:0] qtag_q, qtag_d;
    logic                 st_q, st_d, clr_q, clr_d;

    // clr_q is both the visible flush pulse and the pending wipe for this cycle
    assign head_ent    = ent_q[head];
    assign commit_fire = !clr_q && !empty && head_ent.busy && head_ent.done;
    assign issue_ok    = issue_valid && !full && !clr_q;
    assign cdb_ok      = cdb_valid && !clr_q;

    rob_ring_ptr #(.PW(DEPTH_LOG)) u_ptr (
        .clk_i   (clk_in),
        .rst_n_i (rst_in),
        .en_i    (rdy_in),
        .clr_i   (clr_q),
        .push_i  (issue_ok),
        .pop_i   (commit_fire),
        .head_o  (head),
        .tail_o  (tail),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ent_d = ent_q;
        if (clr_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
                ent_d[i].done = 1'b0;
            end
        end else begin
            if (commit_fire) begin
                ent_d[head].busy = 1'b0;
                ent_d[head].done = 1'b0;
            end
            if (cdb_ok && ent_q[cdb_tag].busy) begin
                ent_d[cdb_tag].done = 1'b1;
                if (ent_q[cdb_tag].kind == ROB_BRANCH) ent_d[cdb_tag].taken = cdb_taken;
                else                                   ent_d[cdb_tag].val   = cdb_val;
            end
            if (issue_ok) begin
                ent_d[tail] = '{busy: 1'b1, done: 1'b0, kind: rob_kind_t'(issue_kind),
                                rd: issue_rd, val: 32'd0, pred: issue_pred_taken,
                                taken: 1'b0, alt_pc: issue_alt_pc};
            end
        end
    end

    always_comb begin
        creg_d = '0;
        cval_d = '0;
        qtag_d = '0;
        st_d   = 1'b0;
        clr_d  = 1'b0;
        cpc_d  = '0;
        if (commit_fire) begin
            case (head_ent.kind)
                ROB_ALU: begin
                    creg_d = head_ent.rd;
                    cval_d = head_ent.val;
                    qtag_d = head;
                end
                ROB_STORE: st_d = 1'b1;
                ROB_BRANCH: begin
                    if (head_ent.taken != head_ent.pred) begin
                        clr_d = 1'b1;
                        cpc_d = head_ent.alt_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            creg_q <= '0;
            cval_q <= '0;
            qtag_q <= '0;
            st_q   <= 1'b0;
            clr_q  <= 1'b0;
            cpc_q  <= '0;
        end else if (rdy_in) begin
            ent_q  <= ent_d;
            creg_q <= creg_d;
            cval_q <= cval_d;
            qtag_q <= qtag_d;
            st_q   <= st_d;
            clr_q  <= clr_d;
            cpc_q  <= cpc_d;
        end
    end

    // a held pulse is shown exactly once, in the first cycle rdy_in is high again
    assign commit_reg   = rdy_in ? creg_q : '0;
    assign commit_q_reg = commit_reg;
    assign commit_val   = rdy_in ? cval_q : '0;
    assign commit_q_tag = rdy_in ? {{(32-DEPTH_LOG){1'b0}}, qtag_q} : '0;
    assign store_commit = rdy_in & st_q;
    assign rob_clear    = rdy_in & clr_q;
    assign clear_pc     = rdy_in ? cpc_q : '0;
    assign issue_tag    = tail;

    logic byp_1, byp_2, st_rdy_1, st_rdy_2;
`ifdef ROB_CDB_BYPASS_EN
    assign byp_1 = cdb_valid && (cdb_tag == query_tag_1);
    assign byp_2 = cdb_valid && (cdb_tag == query_tag_2);
`else
    assign byp_1 = 1'b0;
    assign byp_2 = 1'b0;
`endif
    assign st_rdy_1      = ent_q[query_tag_1].busy && ent_q[query_tag_1].done;
    assign st_rdy_2      = ent_q[query_tag_2].busy && ent_q[query_tag_2].done;
    assign query_ready_1 = byp_1 || st_rdy_1;
    assign query_ready_2 = byp_2 || st_rdy_2;
    assign query_val_1   = byp_1 ? cdb_val : (st_rdy_1 ? ent_q[query_tag_1].val : '0);
    assign query_val_2   = byp_2 ? cdb_val : (st_rdy_2 ? ent_q[query_tag_2].val : '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: hand table, directed corner sequences, then random traffic
// against a program-order queue model of the buffer.
module tb_reorder_buffer;
    import rob_pkg::*;

`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_in, rdy_in, issue_valid, issue_pred_taken, cdb_valid, cdb_taken;
    logic [4:0]  issue_rd, commit_reg, commit_q_reg;
    logic [1:0]  issue_kind;
    logic [31:0] issue_alt_pc, cdb_val, query_val_1, query_val_2, commit_val, commit_q_tag, clear_pc;
    logic [3:0]  issue_tag, cdb_tag, query_tag_1, query_tag_2;
    logic        full, query_ready_1, query_ready_2, store_commit, rob_clear;

    reorder_buffer #(.DEPTH_LOG(4)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_kind(issue_kind),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .issue_tag(issue_tag), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
        .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
        .query_val_1(query_val_1), .query_val_2(query_val_2),
        .commit_reg(commit_reg), .commit_val(commit_val),
        .commit_q_reg(commit_q_reg), .commit_q_tag(commit_q_tag),
        .store_commit(store_commit), .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    typedef struct {
        logic        rdy, iv, pred, cv, ctaken;
        logic [4:0]  rd;
        logic [1:0]  kind;
        logic [31:0] alt, cval;
        logic [3:0]  ctag, q1, q2;
    } in_t;

    typedef struct {
        int          tag;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred, taken, done;
        logic [31:0] alt, val;
    } ment_t;

    typedef struct {
        in_t         s;
        logic [3:0]  e_tag, e_qtag;
        logic [4:0]  e_creg;
        logic        e_r1, e_r2;
        logic [31:0] e_v1;
    } vec_t;

    int          n_chk = 0, n_fail = 0;
    ment_t       mq[$];
    int          m_tail;
    logic [4:0]  m_creg;
    logic [31:0] m_cval, m_cpc;
    logic [3:0]  m_qtag;
    logic        m_st, m_rc;
    vec_t        tbl[10];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic in_t idle();
        in_t s;
        s = '{default: '0};
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic in_t iss(logic [1:0] k, logic [4:0] rd, logic pred, logic [31:0] alt);
        in_t s = idle();
        s.iv = 1'b1; s.kind = k; s.rd = rd; s.pred = pred; s.alt = alt;
        return s;
    endfunction

    function automatic in_t cdb(logic [3:0] t, logic [31:0] v, logic tk);
        in_t s = idle();
        s.cv = 1'b1; s.ctag = t; s.cval = v; s.ctaken = tk;
        return s;
    endfunction

    function automatic void mquery(input logic [3:0] t, input in_t s, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        foreach (mq[i]) if (mq[i].tag == int'(t) && mq[i].done) begin r = 1'b1; v = mq[i].val; end
        if (BYP && s.cv && s.ctag == t) begin r = 1'b1; v = s.cval; end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_tail = 0; m_creg = '0; m_cval = '0; m_cpc = '0; m_qtag = '0; m_st = 1'b0; m_rc = 1'b0;
    endfunction

    function automatic void model_check(in_t s);
        logic r;
        logic [31:0] v;
        chk("commit_reg",   32'(commit_reg),   s.rdy ? 32'(m_creg) : 32'd0);
        chk("commit_q_reg", 32'(commit_q_reg), s.rdy ? 32'(m_creg) : 32'd0);
        chk("commit_val",   commit_val,        s.rdy ? m_cval : 32'd0);
        chk("commit_q_tag", commit_q_tag,      s.rdy ? 32'(m_qtag) : 32'd0);
        chk("store_commit", 32'(store_commit), 32'(s.rdy & m_st));
        chk("rob_clear",    32'(rob_clear),    32'(s.rdy & m_rc));
        chk("clear_pc",     clear_pc,          s.rdy ? m_cpc : 32'd0);
        chk("full",         32'(full),         32'(mq.size() == 16));
        chk("issue_tag",    32'(issue_tag),    32'(m_tail));
        mquery(s.q1, s, r, v);
        chk("query_ready_1", 32'(query_ready_1), 32'(r));
        chk("query_val_1",   query_val_1, v);
        mquery(s.q2, s, r, v);
        chk("query_ready_2", 32'(query_ready_2), 32'(r));
        chk("query_val_2",   query_val_2, v);
    endfunction

    function automatic void model_update(in_t s);
        ment_t e;
        bit    full0;
        if (!s.rdy) return;
        if (m_rc) begin
            model_reset();
            return;
        end
        full0 = (mq.size() == 16);
        m_creg = '0; m_cval = '0; m_qtag = '0; m_st = 1'b0; m_cpc = '0;
        if (mq.size() > 0 && mq[0].done) begin
            e = mq.pop_front();
            case (e.kind)
                ROB_ALU:    begin m_creg = e.rd; m_cval = e.val; m_qtag = e.tag[3:0]; end
                ROB_STORE:  m_st = 1'b1;
                ROB_BRANCH: if (e.taken != e.pred) begin m_rc = 1'b1; m_cpc = e.alt; end
                default: ;
            endcase
        end
        if (s.cv) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(s.ctag) && !mq[i].done) begin
                    mq[i].done = 1'b1;
                    if (mq[i].kind == ROB_BRANCH) mq[i].taken = s.ctaken;
                    else                          mq[i].val   = s.cval;
                end
            end
        end
        if (s.iv && !full0) begin
            e = '{tag: m_tail, kind: s.kind, rd: s.rd, pred: s.pred, taken: 1'b0,
                  done: 1'b0, alt: s.alt, val: 32'd0};
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endfunction

    task automatic drive(input in_t s);
        rdy_in = s.rdy; issue_valid = s.iv; issue_rd = s.rd; issue_kind = s.kind;
        issue_pred_taken = s.pred; issue_alt_pc = s.alt;
        cdb_valid = s.cv; cdb_tag = s.ctag; cdb_val = s.cval; cdb_taken = s.ctaken;
        query_tag_1 = s.q1; query_tag_2 = s.q2;
    endtask

    task automatic step(input in_t s);
        drive(s);
        #1;
        model_check(s);
    endtask

    task automatic fin(input in_t s);
        model_update(s);
        @(negedge clk);
    endtask

    task automatic cyc(input in_t s);
        step(s);
        fin(s);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        drive(idle());
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("rst_full", 32'(full), 0);
        chk("rst_issue_tag", 32'(issue_tag), 0);
        chk("rst_commit_reg", 32'(commit_reg), 0);
        chk("rst_rob_clear", 32'(rob_clear), 0);
        chk("rst_store_commit", 32'(store_commit), 0);
        chk("rst_query_ready", 32'(query_ready_1), 0);
        @(negedge clk);
    endtask

    function automatic vec_t mkv(logic iv, logic [4:0] rd, logic cv, logic [3:0] ct, logic [31:0] cv_val,
                                 logic [3:0] q1, logic [3:0] q2, logic [3:0] e_tag, logic [4:0] e_creg,
                                 logic [3:0] e_qtag, logic e_r1, logic [31:0] e_v1, logic e_r2);
        vec_t v;
        v.s = idle();
        v.s.iv = iv; v.s.rd = rd; v.s.kind = ROB_ALU;
        v.s.cv = cv; v.s.ctag = ct; v.s.cval = cv_val; v.s.q1 = q1; v.s.q2 = q2;
        v.e_tag = e_tag; v.e_creg = e_creg; v.e_qtag = e_qtag;
        v.e_r1 = e_r1; v.e_v1 = e_v1; v.e_r2 = e_r2;
        return v;
    endfunction

    initial begin
        in_t s;
        int  cand[$];
        int  k;

        // three ALU ops completing out of order must retire in program order
        tbl[0] = mkv(1, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0,   0,                   0);
        tbl[1] = mkv(1, 2, 0, 0, 0,     0, 0, 1, 0, 0, 0,   0,                   0);
        tbl[2] = mkv(1, 3, 0, 0, 0,     0, 0, 2, 0, 0, 0,   0,                   0);
        tbl[3] = mkv(0, 0, 1, 1, 'h11,  1, 0, 3, 0, 0, BYP, BYP ? 32'h11 : 32'h0, 0);
        tbl[4] = mkv(0, 0, 1, 0, 'h10,  1, 0, 3, 0, 0, 1,   'h11,                BYP);
        tbl[5] = mkv(0, 0, 1, 2, 'h12,  0, 2, 3, 0, 0, 1,   'h10,                BYP);
        tbl[6] = mkv(0, 0, 0, 0, 0,     2, 0, 3, 1, 0, 1,   'h12,                0);
        tbl[7] = mkv(0, 0, 0, 0, 0,     0, 0, 3, 2, 1, 0,   0,                   0);
        tbl[8] = mkv(0, 0, 0, 0, 0,     0, 0, 3, 3, 2, 0,   0,                   0);
        tbl[9] = mkv(0, 0, 0, 0, 0,     0, 0, 3, 0, 0, 0,   0,                   0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].s);
            #1;
            chk("tbl_issue_tag",   32'(issue_tag),     32'(tbl[i].e_tag));
            chk("tbl_commit_reg",  32'(commit_reg),    32'(tbl[i].e_creg));
            chk("tbl_commit_qtag", commit_q_tag,       32'(tbl[i].e_qtag));
            chk("tbl_q1_ready",    32'(query_ready_1), 32'(tbl[i].e_r1));
            chk("tbl_q1_val",      query_val_1,        tbl[i].e_v1);
            chk("tbl_q2_ready",    32'(query_ready_2), 32'(tbl[i].e_r2));
            model_check(tbl[i].s);
            fin(tbl[i].s);
        end

        // fill to 16, reject the 17th, then commit one and refill
        do_reset();
        for (int i = 0; i < 16; i++) cyc(iss(ROB_ALU, 5'(i + 1), 1'b0, 32'd0));
        chk("full_set", 32'(full), 1);
        chk("full_tag_wrap", 32'(issue_tag), 0);
        cyc(iss(ROB_ALU, 5'd20, 1'b0, 32'd0));
        chk("full_17th_full", 32'(full), 1);
        chk("full_17th_tag", 32'(issue_tag), 0);
        cyc(cdb(4'd0, 32'hA0, 1'b0));
        cyc(idle());
        chk("full_commit_reg", 32'(commit_reg), 1);
        chk("full_drop", 32'(full), 0);
        cyc(iss(ROB_ALU, 5'd21, 1'b0, 32'd0));
        chk("full_refill", 32'(full), 1);
        chk("full_refill_tag", 32'(issue_tag), 1);

        // mispredicted branch flushes younger work
        do_reset();
        cyc(iss(ROB_BRANCH, 5'd0, 1'b1, 32'h1000));
        cyc(iss(ROB_ALU, 5'd7, 1'b0, 32'd0));
        cyc(cdb(4'd1, 32'h77, 1'b0));
        cyc(cdb(4'd0, 32'd0, 1'b0));
        cyc(idle());
        chk("mp_clear", 32'(rob_clear), 1);
        chk("mp_clear_pc", clear_pc, 32'h1000);
        chk("mp_no_reg", 32'(commit_reg), 0);
        cyc(iss(ROB_ALU, 5'd8, 1'b0, 32'd0));
        chk("mp_clear_one_cycle", 32'(rob_clear), 0);
        chk("mp_tag_zero", 32'(issue_tag), 0);
        chk("mp_young_dropped", 32'(commit_reg), 0);
        cyc(idle());
        chk("mp_young_never", 32'(commit_reg), 0);

        // store at head
        do_reset();
        cyc(iss(ROB_STORE, 5'd9, 1'b0, 32'd0));
        cyc(cdb(4'd0, 32'h99, 1'b0));
        cyc(idle());
        chk("st_pulse", 32'(store_commit), 1);
        chk("st_no_reg", 32'(commit_reg), 0);
        cyc(idle());
        chk("st_pulse_end", 32'(store_commit), 0);

        // CDB forwarding onto the query port
        do_reset();
        for (int i = 0; i < 6; i++) cyc(iss(ROB_ALU, 5'(10 + i), 1'b0, 32'd0));
        s = cdb(4'd5, 32'hDEADBEEF, 1'b0);
        s.q1 = 4'd5;
        step(s);
        chk("byp_same_ready", 32'(query_ready_1), 32'(BYP));
        chk("byp_same_val", query_val_1, BYP ? 32'hDEADBEEF : 32'h0);
        fin(s);
        s = idle();
        s.q1 = 4'd5;
        step(s);
        chk("byp_next_ready", 32'(query_ready_1), 1);
        chk("byp_next_val", query_val_1, 32'hDEADBEEF);
        fin(s);

        // stall with the head done, then release
        cyc(cdb(4'd0, 32'h55, 1'b0));
        for (int i = 0; i < 3; i++) begin
            s = iss(ROB_ALU, 5'd30, 1'b0, 32'd0);
            s.rdy = 1'b0;
            step(s);
            chk("rdy_no_commit", 32'(commit_reg), 0);
            fin(s);
        end
        chk("rdy_hold_tag", 32'(issue_tag), 6);
        cyc(idle());
        chk("rdy_commit_reg", 32'(commit_reg), 10);
        chk("rdy_commit_val", commit_val, 32'h55);
        chk("rdy_commit_qtag", commit_q_tag, 0);

        // random traffic against the queue model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            s = idle();
            s.rdy  = ($urandom_range(9, 0) != 0);
            s.iv   = ($urandom_range(9, 0) < 6);
            s.kind = 2'($urandom_range(2, 0));
            s.rd   = 5'($urandom);
            s.pred = 1'($urandom);
            s.alt  = $urandom;
            s.q1   = 4'($urandom);
            s.q2   = 4'($urandom);
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(9, 0) < 6) begin
                k = cand[$urandom_range(cand.size() - 1, 0)];
                s.cv     = 1'b1;
                s.ctag   = mq[k].tag[3:0];
                s.cval   = $urandom;
                s.ctaken = ($urandom_range(3, 0) == 0) ? !mq[k].pred : mq[k].pred;
            end
            cyc(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
